// File: rtl/serial_boot_loader_pkg.sv
// Shared definitions for the serial boot loader: frame marker, write mask and
// the state encodings of the frame FSM and the UART receiver.
package serial_boot_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [3:0] MEM_MASK_ALL      = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/serial_boot_loader_uart_rx.sv
// 8N1 UART receiver: synchronises rx, validates the start bit at half a bit time,
// samples data LSB-first at mid-bit and reports either a byte or a framing error.
module serial_boot_loader_uart_rx
    import serial_boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       ferr
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        rx_state, rx_next;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // Line idles high, so the synchroniser resets to 1 to avoid a phantom start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
            // which is what makes this a real three-stage shift chain.
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        // NOTE: default first, so every path assigns rx_next and no latch is inferred.
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
            RX_START: if (cnt == HALF_LAST) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt == BIT_LAST && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (cnt == BIT_LAST) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            ferr       <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            ferr       <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                end
                RX_START: cnt <= (cnt == HALF_LAST) ? '0 : cnt + CNT_W'(1);
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        byte_valid <= rx_sync;
                        ferr       <= !rx_sync;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign rx_byte = shift;

endmodule

// File: rtl/serial_boot_loader.sv
// Boot loader: parses a sync/length/data/checksum frame from the UART, writes the
// image into program memory, and releases the CPU reset once the checksum matches.
module serial_boot_loader
    import serial_boot_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT  = 868,
    parameter int         D_WIDTH       = 32,
    parameter int         D_DEPTH_WIDTH = 10,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx,
    output logic                     mem_en,
    output logic [3:0]               mem_wr_mask,
    output logic [D_DEPTH_WIDTH-1:0] mem_addr,
    output logic [D_WIDTH-1:0]       mem_data,
    output logic                     mem_sel,
    output logic                     cpu_rst,
    output logic                     done,
    output logic                     error
);

    localparam int          ADDR_W    = D_DEPTH_WIDTH + 1;
    localparam int unsigned MAX_WORDS = 2 ** D_DEPTH_WIDTH;

    state_t            state, next_state;
    logic              byte_valid, ferr;
    logic [7:0]        rx_byte;
    logic [15:0]       len;
    logic [15:0]       len_candidate;
    logic [ADDR_W-1:0] word_addr;
    logic [1:0]        byte_idx;
    logic [7:0]        csum;
    logic              last_word;

    serial_boot_loader_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .ferr       (ferr)
    );

    assign len_candidate = {rx_byte, len[7:0]};
    // Address is one bit wider than mem_addr so N = 2**D_DEPTH_WIDTH ends without wrapping.
    assign last_word     = (17'(word_addr) + 17'd1) == {1'b0, len};
    assign mem_addr      = word_addr[D_DEPTH_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        mem_en      = 1'b0;
        mem_wr_mask = 4'h0;
        done        = (state == ST_DONE);
        error       = (state == ST_ERROR);
        cpu_rst     = (state != ST_DONE);
        mem_sel     = (state != ST_DONE);

        if (state == ST_WRITE) begin
            mem_en      = 1'b1;
            mem_wr_mask = MEM_MASK_ALL;
        end

        if (ferr && state != ST_DONE) begin
            next_state = ST_ERROR;
        end else begin
            case (state)
                ST_IDLE, ST_ERROR:
                    if (byte_valid && rx_byte == SYNC_BYTE) next_state = ST_LEN_LO;
                ST_LEN_LO:
                    if (byte_valid) next_state = ST_LEN_HI;
                ST_LEN_HI:
                    if (byte_valid) begin
                        if (32'(len_candidate) > MAX_WORDS) next_state = ST_ERROR;
                        else if (len_candidate == 16'd0)    next_state = ST_CSUM;
                        else                                next_state = ST_DATA;
                    end
                ST_DATA:
                    if (byte_valid && byte_idx == 2'd3) next_state = ST_WRITE;
                ST_WRITE:
                    next_state = last_word ? ST_CSUM : ST_DATA;
                ST_CSUM:
                    if (byte_valid) next_state = (rx_byte == csum) ? ST_DONE : ST_ERROR;
                ST_DONE:
                    next_state = ST_DONE;
                default:
                    next_state = ST_IDLE;
            endcase
        end
    end

    // Frame datapath: length, word assembler, address counter and running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len       <= '0;
            word_addr <= '0;
            byte_idx  <= '0;
            csum      <= '0;
            mem_data  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ERROR:
                    if (byte_valid && rx_byte == SYNC_BYTE) csum <= '0;
                ST_LEN_LO:
                    if (byte_valid) len[7:0] <= rx_byte;
                ST_LEN_HI:
                    if (byte_valid) begin
                        len[15:8] <= rx_byte;
                        word_addr <= '0;
                        byte_idx  <= '0;
                    end
                ST_DATA:
                    if (byte_valid) begin
                        mem_data[{byte_idx, 3'b000} +: 8] <= rx_byte;
                        csum     <= csum ^ rx_byte;
                        byte_idx <= byte_idx + 2'd1;
                    end
                ST_WRITE:
                    word_addr <= word_addr + ADDR_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_boot_loader.sv
// Directed bench for serial_boot_loader: drives UART frames and scoreboards memory writes.
module tb_serial_boot_loader;

    localparam int CPB = 4;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;
    typedef logic [7:0] bytes_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        mem_en;
    logic [3:0]  mem_wr_mask;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_sel, cpu_rst, done, error;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   writes   = 0;
    logic prev_en  = 1'b0;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    serial_boot_loader #(
        .CLKS_PER_BIT  (CPB),
        .D_WIDTH       (32),
        .D_DEPTH_WIDTH (10),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .mem_en      (mem_en),
        .mem_wr_mask (mem_wr_mask),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_sel     (mem_sel),
        .cpu_rst     (cpu_rst),
        .done        (done),
        .error       (error)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input logic cr, input logic sel);
        check({tag, ".done"},    64'(done),    64'(d));
        check({tag, ".error"},   64'(error),   64'(e));
        check({tag, ".cpu_rst"}, 64'(cpu_rst), 64'(cr));
        check({tag, ".mem_sel"}, 64'(mem_sel), 64'(sel));
    endtask

    // Write monitor: every mem_en pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            writes++;
            check("mem_en_single_cycle", 64'(prev_en), 64'(0));
            check("mem_wr_mask", 64'(mem_wr_mask), 64'(4'hF));
            check("write_expected", 64'(exp_q.size() == 0), 64'(0));
            if (exp_q.size() != 0) begin
                wr_t w;
                w = exp_q.pop_front();
                check("mem_addr", 64'(mem_addr), 64'(w.addr));
                check("mem_data", 64'(mem_data), 64'(w.data));
            end
        end
        prev_en = mem_en;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input bytes_t f);
        foreach (f[i]) send_byte(f[i]);
        repeat (4) @(negedge clk);
    endtask

    task automatic push_word(input logic [9:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bytes_t frame_a, frame_bad, frame_b;
        frame_a   = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                      8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        frame_bad = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                      8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B};
        frame_b   = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.mem_en", 64'(mem_en), 64'(0));
        check("rst.mem_wr_mask", 64'(mem_wr_mask), 64'(0));
        check("rst.mem_addr", 64'(mem_addr), 64'(0));
        check("rst.mem_data", 64'(mem_data), 64'(0));
        check_status("rst", 1'b0, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two-word load
        push_word(10'd0, 32'h12345678);
        push_word(10'd1, 32'hDEADBEEF);
        send_frame(frame_a);
        check_status("load_a", 1'b1, 1'b0, 1'b0, 1'b0);
        check("load_a.writes", 64'(writes), 64'(2));
        check("load_a.queue", 64'(exp_q.size()), 64'(0));

        // DONE ignores new sync and framing errors
        send_byte(8'hA5);
        send_byte(8'h00, 1'b0);
        repeat (4) @(negedge clk);
        check_status("done_hold", 1'b1, 1'b0, 1'b0, 1'b0);
        check("done_hold.writes", 64'(writes), 64'(2));

        // Bad checksum, then recovery by resending
        do_reset();
        writes = 0;
        push_word(10'd0, 32'h12345678);
        push_word(10'd1, 32'hDEADBEEF);
        send_frame(frame_bad);
        check_status("bad_csum", 1'b0, 1'b1, 1'b1, 1'b1);
        check("bad_csum.writes", 64'(writes), 64'(2));
        push_word(10'd0, 32'h12345678);
        push_word(10'd1, 32'hDEADBEEF);
        send_frame(frame_a);
        check_status("resend", 1'b1, 1'b0, 1'b0, 1'b0);
        check("resend.writes", 64'(writes), 64'(4));

        // Leading garbage is ignored
        do_reset();
        writes = 0;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        repeat (4) @(negedge clk);
        check_status("garbage", 1'b0, 1'b0, 1'b1, 1'b1);
        push_word(10'd0, 32'h04030201);
        send_frame(frame_b);
        check_status("after_garbage", 1'b1, 1'b0, 1'b0, 1'b0);
        check("after_garbage.writes", 64'(writes), 64'(1));

        // Oversize length, then a zero-length frame recovers from ERROR
        do_reset();
        writes = 0;
        send_frame('{8'hA5, 8'h01, 8'h04});
        check_status("len_1025", 1'b0, 1'b1, 1'b1, 1'b1);
        send_frame('{8'hA5, 8'h00, 8'h00, 8'h00});
        check_status("len_0", 1'b1, 1'b0, 1'b0, 1'b0);
        check("len_0.writes", 64'(writes), 64'(0));

        // Glitch is rejected; stop bit 0 after sync flags an error
        do_reset();
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (6 * CPB) @(negedge clk);
        check_status("glitch", 1'b0, 1'b0, 1'b1, 1'b1);
        send_byte(8'hA5);
        check_status("sync_only", 1'b0, 1'b0, 1'b1, 1'b1);
        send_byte(8'h12, 1'b0);
        repeat (4) @(negedge clk);
        check_status("ferr", 1'b0, 1'b1, 1'b1, 1'b1);

        // Reset mid-frame discards the partial word
        do_reset();
        writes = 0;
        for (int i = 0; i < 5; i++) send_byte(frame_a[i]);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.mem_data", 64'(mem_data), 64'(0));
        check("midrst.mem_addr", 64'(mem_addr), 64'(0));
        check("midrst.mem_en", 64'(mem_en), 64'(0));
        check_status("midrst", 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_word(10'd0, 32'h12345678);
        push_word(10'd1, 32'hDEADBEEF);
        send_frame(frame_a);
        check_status("after_midrst", 1'b1, 1'b0, 1'b0, 1'b0);
        check("after_midrst.writes", 64'(writes), 64'(2));
        check("final.queue", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
